// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared types and constants for the tone receive path.
//   - note_t / NOTE_C..NOTE_B : chromatic note index, C4 = 0 .. B4 = 11
//   - NOMINAL_PERIOD[0..11]   : ideal full periods in 25 MHz cycles
//   - BOUND[0..12]            : bin edges; note i covers BOUND[i+1] <= p < BOUND[i]
//   - meter_state_t           : period meter FSM states
// ---------------------------------------------------------------------------
package tone_pkg;

  localparam int unsigned CLK_HZ    = 25_000_000;
  localparam int          NUM_NOTES = 12;

  typedef logic [3:0] note_t;

  localparam note_t NOTE_C  = 4'd0;
  localparam note_t NOTE_CS = 4'd1;
  localparam note_t NOTE_D  = 4'd2;
  localparam note_t NOTE_DS = 4'd3;
  localparam note_t NOTE_E  = 4'd4;
  localparam note_t NOTE_F  = 4'd5;
  localparam note_t NOTE_FS = 4'd6;
  localparam note_t NOTE_G  = 4'd7;
  localparam note_t NOTE_GS = 4'd8;
  localparam note_t NOTE_A  = 4'd9;
  localparam note_t NOTE_AS = 4'd10;
  localparam note_t NOTE_B  = 4'd11;

  // Ideal periods, C4..B4.
  localparam int unsigned NOMINAL_PERIOD [NUM_NOTES] = '{
    95556, 90193, 85131, 80353, 75843, 71586,
    67569, 63776, 60197, 56818, 53629, 50619
  };

  // Inner edges are floor midpoints of neighbouring nominals; the outer two
  // are the midpoints towards B3 (top) and C5 (bottom).
  localparam int unsigned BOUND [NUM_NOTES+1] = '{
    98397, 92874, 87662, 82742, 78098, 73714, 69577,
    65672, 61986, 58507, 55223, 52124, 49198
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/tone_decoder_if.sv
// ---------------------------------------------------------------------------
// tone_decoder_if
// Bundles the tone input and the decoded results.
//   TONE_IN      : raw square wave into the decoder
//   NOTE         : decoded note index
//   NOTE_VALID   : NOTE is a stable, in-range decode
//   NOTE_CHANGE  : single-cycle pulse on a new/changed valid note
//   PERIOD       : last measured period in clock cycles
//   PERIOD_VALID : single-cycle pulse when PERIOD updates
// Modports: slave = decoder side, master = source/consumer side.
// ---------------------------------------------------------------------------
interface tone_decoder_if #(
  parameter int CNT_W = 17
);
  import tone_pkg::*;

  logic             TONE_IN;
  note_t            NOTE;
  logic             NOTE_VALID;
  logic             NOTE_CHANGE;
  logic [CNT_W-1:0] PERIOD;
  logic             PERIOD_VALID;

  modport master (
    output TONE_IN,
    input  NOTE, NOTE_VALID, NOTE_CHANGE, PERIOD, PERIOD_VALID
  );

  modport slave (
    input  TONE_IN,
    output NOTE, NOTE_VALID, NOTE_CHANGE, PERIOD, PERIOD_VALID
  );

endinterface

// File: rtl/tone_period_meter.sv
// ---------------------------------------------------------------------------
// tone_period_meter
// Synchronises TONE_IN, detects rising edges and measures rise-to-rise
// periods in clock cycles. A missing edge for TIMEOUT_CYCLES drops back to
// IDLE so the next edge starts a fresh measurement.
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   tone_i         : asynchronous square wave
//   period_o       : last measured period
//   period_valid_o : single-cycle pulse when period_o updates
//   timeout_o      : single-cycle pulse (combinational) on tone loss
// ---------------------------------------------------------------------------
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 98398,
  parameter int          CNT_W          = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tone_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             sync_prev_q;
  logic             rise_q;
  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic             timeout;

  // Input path: two synchroniser flops then a registered rising-edge detect,
  // so rise_q appears three clocks after the input edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b00;
      sync_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], tone_i};
      sync_prev_q <= sync_q[1];
      rise_q      <= sync_q[1] & ~sync_prev_q;
    end
  end

  // FSM state register plus the datapath registers it steers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end

  // Next-state logic. A rise always beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rise_q) state_d = ST_MEASURE;
      ST_MEASURE: if (!rise_q && (cnt_q >= CNT_LIM)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = rise_q ? CNT_ONE : '0;
      end
      ST_MEASURE: begin
        if (rise_q) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          cnt_d    = CNT_ONE;
        end else if (cnt_q >= CNT_LIM) begin
          timeout = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign timeout_o      = timeout;

endmodule

// File: rtl/tone_decoder.sv
// ---------------------------------------------------------------------------
// tone_decoder
// Classifies measured tone periods into chromatic notes C4..B4 and only
// reports a note once it has been seen for STABLE_COUNT consecutive periods.
//   CLK     : 25 MHz system clock
//   RESET_N : asynchronous active-low reset
//   bus     : tone_decoder_if.slave (TONE_IN in; NOTE, NOTE_VALID,
//             NOTE_CHANGE, PERIOD, PERIOD_VALID out)
// Latency: NOTE/NOTE_VALID update two cycles after PERIOD_VALID.
// ---------------------------------------------------------------------------
module tone_decoder
  import tone_pkg::*;
#(
  parameter int          STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 98398,
  parameter int          CNT_W          = 17
) (
  input  logic           CLK,
  input  logic           RESET_N,
  tone_decoder_if.slave  bus
);

  localparam int             RUN_W   = (STABLE_COUNT < 2) ? 1 : $clog2(STABLE_COUNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;

  tone_period_meter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_meter (
    .clk_i          (CLK),
    .rst_ni         (RESET_N),
    .tone_i         (bus.TONE_IN),
    .period_o       (period),
    .period_valid_o (period_valid),
    .timeout_o      (timeout)
  );

  // ---------------- Classifier ----------------
  logic [31:0]          period_ext;
  logic [NUM_NOTES-1:0] hit;
  note_t                cls_bin_d, cls_bin_q;
  logic                 cls_in_d, cls_in_q;
  logic                 cls_valid_q;

  assign period_ext = 32'(period);

  // One window comparator per note; windows are disjoint so at most one hits.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NOTES; gi++) begin : g_bin
      assign hit[gi] = (period_ext >= BOUND[gi+1]) && (period_ext < BOUND[gi]);
    end
  endgenerate

  always_comb begin
    cls_bin_d = NOTE_C;
    cls_in_d  = |hit;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (hit[i]) cls_bin_d = note_t'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cls_valid_q <= 1'b0;
      cls_bin_q   <= NOTE_C;
      cls_in_q    <= 1'b0;
    end else begin
      cls_valid_q <= period_valid;
      if (period_valid) begin
        cls_bin_q <= cls_bin_d;
        cls_in_q  <= cls_in_d;
      end
    end
  end

  // ---------------- Stability filter ----------------
  // run_q == 0 means "no candidate", so candidate index 0 (C) is unambiguous.
  note_t            cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  note_t            note_q, note_d;
  logic             nv_q, nv_d;
  logic             chg_q, chg_d;

  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    note_d = note_q;
    nv_d   = nv_q;
    chg_d  = 1'b0;
    if (timeout) begin
      nv_d   = 1'b0;
      run_d  = '0;
      cand_d = NOTE_C;
    end else if (cls_valid_q) begin
      if (!cls_in_q) begin
        nv_d   = 1'b0;
        run_d  = '0;
        cand_d = NOTE_C;
      end else begin
        if ((run_q != '0) && (cls_bin_q == cand_q)) begin
          run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
        end else begin
          cand_d = cls_bin_q;
          run_d  = RUN_ONE;
        end
        // Until the new candidate matures, the previous NOTE/NOTE_VALID hold.
        if (run_d == RUN_MAX) begin
          note_d = cand_d;
          nv_d   = 1'b1;
          chg_d  = !nv_q || (note_q != cand_d);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cand_q <= NOTE_C;
      run_q  <= '0;
      note_q <= NOTE_C;
      nv_q   <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
      note_q <= note_d;
      nv_q   <= nv_d;
      chg_q  <= chg_d;
    end
  end

  assign bus.NOTE         = note_q;
  assign bus.NOTE_VALID   = nv_q;
  assign bus.NOTE_CHANGE  = chg_q;
  assign bus.PERIOD       = period;
  assign bus.PERIOD_VALID = period_valid;

endmodule
